// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit bridging a request/response handshake to a block RAM port
module mem_lsu #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_wstrb,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t r_state, w_next;
  logic w_accept, w_err;
  logic r_we, r_uns, r_err;
  logic [1:0] r_size, r_off;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  assign w_err = (&req_size) | ((req_size == 2'b01) & req_addr[0]) |
                 ((req_size == 2'b10) & (|req_addr[1:0])) | (|(req_addr >> (ADDR_WIDTH + 2)));
  assign req_ready = ~rst & ((r_state == IDLE) | rsp_ready);
  assign w_accept = req_valid & req_ready;
  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // enter RESP on every accept, leave it once the response is consumed
  always_comb
    w_next = w_accept ? RESP : ((r_state == RESP) & rsp_ready) ? IDLE : r_state;
  // capture the attributes needed to format the response
  always_ff @(posedge clk)
    if (w_accept) begin
      r_we   <= req_we;
      r_size <= req_size;
      r_uns  <= req_unsigned;
      r_off  <= req_addr[1:0];
      r_err  <= w_err;
    end
  // RAM port drive in the accept cycle and response formatting from the held RAM output
  always_comb begin
    rsp_valid = ~rst & (r_state == RESP);
    mem_en    = w_accept & ~w_err;
    mem_we    = mem_en & req_we;
    mem_addr  = req_addr[ADDR_WIDTH+1:2];
    mem_wdata = (req_size == 2'b00) ? {4{req_wdata[7:0]}} :
                (req_size == 2'b01) ? {2{req_wdata[15:0]}} : req_wdata;
    mem_wstrb = ~mem_we ? 4'b0000 :
                (req_size == 2'b00) ? 4'b0001 << req_addr[1:0] :
                (req_size == 2'b01) ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_byte    = mem_rdata[8*r_off +: 8];
    w_half    = mem_rdata[16*r_off[1] +: 16];
    w_load    = (r_size == 2'b00) ? {{24{~r_uns & w_byte[7]}}, w_byte} :
                (r_size == 2'b01) ? {{16{~r_uns & w_half[15]}}, w_half} : mem_rdata;
    rsp_err   = rsp_valid & r_err;
    rsp_rdata = (rsp_valid & ~r_we & ~r_err) ? w_load : 32'h0;
  end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: scoreboard bench for mem_lsu with a behavioural block RAM
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, req_we, req_unsigned, rsp_valid, rsp_ready, rsp_err, mem_en, mem_we;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic [9:0] mem_addr;
  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  logic [32:0] q[$];
  logic [32:0] mon_e;
  int tests = 0, fails = 0;
  int w;

  mem_lsu #(.ADDR_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else mem_rdata <= ram[mem_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bad(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a[31:12] != 20'd0;
  endfunction

  function automatic logic [3:0] strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0: return 4'b0001 << off;
      2'd1: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [32:0] exp_rsp(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] wd;
    logic [7:0] b;
    logic [15:0] h;
    if (bad(sz, a)) return {1'b1, 32'h0};
    if (we) return 33'h0;
    wd = ref_mem[a[11:2]];
    b = wd[8*a[1:0] +: 8];
    h = wd[16*a[1] +: 16];
    case (sz)
      2'd0: return {1'b0, uns ? 24'h0 : {24{b[7]}}, b};
      2'd1: return {1'b0, uns ? 16'h0 : {16{h[15]}}, h};
      default: return {1'b0, wd};
    endcase
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] d, output int waited);
    logic e;
    logic [3:0] s;
    logic [31:0] wd;
    e = bad(sz, a);
    s = (we && !e) ? strb(sz, a[1:0]) : 4'h0;
    wd = (sz == 2'd0) ? {4{d[7:0]}} : (sz == 2'd1) ? {2{d[15:0]}} : d;
    q.push_back(exp_rsp(we, sz, uns, a));
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    chk("mem_en", {31'd0, mem_en}, {31'd0, !e});
    chk("mem_we", {31'd0, mem_we}, {31'd0, we && !e});
    chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, s});
    if (!e) chk("mem_addr", {22'd0, mem_addr}, {22'd0, a[11:2]});
    if (we && !e) begin
      chk("mem_wdata", mem_wdata, wd);
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[a[11:2]][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (!rst && rsp_valid && rsp_ready) begin
      if (q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e[32]});
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
      end
    end

  initial begin
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, w);
    chk("first_accept_wait", w, 0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, w);
    @(negedge clk);
    chk("lw_latency", {31'd0, rsp_valid}, 32'd1);
    @(posedge clk);
    #1;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h80FF7F01, w);
    do_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, w);
    do_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0, w);
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, w);
    do_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, w);
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AB, w);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, w);
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0, w);
    do_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0, w);
    do_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, w);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h55AA55AA, w);
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, w);
    q.push_back(exp_rsp(1'b0, 2'd0, 1'b1, 32'h23));
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h23;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      chk("stall_mem_en", {31'd0, mem_en}, 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("release_req_ready", {31'd0, req_ready}, 32'd1);
    chk("release_mem_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, w);
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    @(negedge clk);
    chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
    void'(q.pop_back());
    @(posedge clk);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    q.push_back(exp_rsp(1'b0, 2'd2, 1'b0, 32'h10));
    @(negedge clk);
    chk("post_rst_idle", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_mem_en", {31'd0, mem_en}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 64; i++) do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, w);
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if (i % 9 == 0) a = a | 32'h1000;
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, w);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width of the attached block RAM port (RAM depth 2^ADDR_WIDTH 32-bit words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request accepted when req_valid & req_ready at a rising edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid & rsp_ready at a rising edge.
REQ-013 rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-014 rsp_err  output  1  request was misaligned, illegal size or out of range.
REQ-015 mem_en, mem_we  output  1 each  RAM port enable / write enable.
REQ-016 mem_wstrb  output  4  RAM byte write strobes.
REQ-017 mem_addr  output  ADDR_WIDTH  RAM word address = req_addr[ADDR_WIDTH+1:2].
REQ-018 mem_wdata  output  32  RAM write data, lane-replicated.
REQ-019 mem_rdata  input  32  RAM read data, valid one cycle after mem_en with mem_we=0, held stable while mem_en=0.

Function
REQ-020 States IDLE (no response outstanding) and RESP (rsp_valid=1); at most one request outstanding.
REQ-021 req_ready = ~rst & (state==IDLE | rsp_ready); back-to-back accept allowed in the cycle a response is consumed.
REQ-022 Error check on accept: size 11; half with addr[0]=1; word with addr[1:0]!=0; any of req_addr[31:ADDR_WIDTH+2] nonzero.
REQ-023 mem_en = accept & ~error, combinational in the accept cycle; mem_we = mem_en & req_we; no RAM access otherwise.
REQ-024 Store byte: mem_wdata = 4 copies of wdata[7:0], mem_wstrb = 0001 << addr[1:0].
REQ-025 Store half: mem_wdata = 2 copies of wdata[15:0], mem_wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
REQ-026 Store word: mem_wdata = wdata, mem_wstrb = 1111; mem_wstrb = 0000 whenever mem_we=0.
REQ-027 Accept registers we, size, unsigned, addr[1:0], error; state -> RESP at next edge; response appears exactly one cycle after accept.
REQ-028 Load format in RESP from mem_rdata combinationally: byte = mem_rdata[8*off +: 8], half = mem_rdata[16*off[1] +: 16], word = mem_rdata; extend per registered unsigned flag.
REQ-029 Because mem_en is low while a response waits, mem_rdata is stable; rsp_rdata stays constant for the whole RESP stall.
REQ-030 RESP -> IDLE on rsp_ready without new accept; RESP -> RESP on rsp_ready with new accept; stays RESP while rsp_ready=0.
REQ-031 Store and error responses: rsp_rdata = 0; rsp_err = registered error flag; rsp_err = 0 when rsp_valid = 0.
REQ-032 rsp_rdata = 0 when rsp_valid = 0.

Reset
REQ-033 While rst=1: state IDLE, rsp_valid 0, req_ready 0, mem_en 0, mem_we 0, mem_wstrb 0, rsp_err 0, rsp_rdata 0.
REQ-034 Reset mid-operation drops any outstanding response; no RAM access issued in the reset cycle even if req_valid=1.
REQ-035 First request accepted in the first cycle with rst=0.

Verification
REQ-036 SW addr 0x10 data 0xDEADBEEF -> mem_addr 4, wstrb 1111; LW 0x10 next -> rsp_rdata 0xDEADBEEF one cycle after accept, rsp_err 0.
REQ-037 Word at 0x20 = 0x80FF7F01: LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
REQ-038 SB 0x21 data 0xAB -> mem_wdata 0xABABABAB, wstrb 0010; SH 0x22 data 0x1234 -> wdata 0x12341234, wstrb 1100.
REQ-039 LW 0x02, LH 0x01, size 11, addr 0x1000 (ADDR_WIDTH 10) -> mem_en never asserted, rsp_err 1, rsp_rdata 0.
REQ-040 Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata constant, req_ready 0, mem_en 0; on release a queued request is accepted in the same cycle.
REQ-041 rst asserted in RESP with rsp_ready 0 -> next cycle rsp_valid 0, state IDLE, no RAM access.
